// File: rtl/if1_fetch_buffer_if.sv
// IF1 fetch-buffer bus: IF0 request handshake, icache response, and the
// aligned entry handed to the instruction FIFO.
interface if1_fetch_buffer_if #(
    parameter int unsigned FETCH_W = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [31:0]            req_pc;

    logic                   resp_valid;
    logic [FETCH_W*32-1:0]  resp_inst;
    logic [31:0]            resp_pc_next;
    logic                   resp_taken;
    logic [31:0]            resp_badv;
    logic [6:0]             resp_excp;
    logic [1:0]             resp_excp_flag;

    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [31:0]            out_pc_next;
    logic [31:0]            out_badv;
    logic                   out_taken;
    logic [6:0]             out_excp;
    logic [1:0]             out_excp_flag;
    logic [FETCH_W*32-1:0]  out_inst;
    logic [FETCH_W-1:0]     out_mask;

    modport master (
        output req_valid, req_pc,
        output resp_valid, resp_inst, resp_pc_next, resp_taken, resp_badv, resp_excp, resp_excp_flag,
        output out_ready,
        input  req_ready,
        input  out_valid, out_pc, out_pc_next, out_badv, out_taken, out_excp, out_excp_flag,
        input  out_inst, out_mask
    );

    modport slave (
        input  req_valid, req_pc,
        input  resp_valid, resp_inst, resp_pc_next, resp_taken, resp_badv, resp_excp, resp_excp_flag,
        input  out_ready,
        output req_ready,
        output out_valid, out_pc, out_pc_next, out_badv, out_taken, out_excp, out_excp_flag,
        output out_inst, out_mask
    );
endinterface

// File: rtl/if1_fetch_buffer.sv
// IF1 stage: credit-tracked icache requests, in-order PC queue, lane alignment
// and a registered skid FIFO toward the instruction FIFO; drops post-flush responses.
module if1_fetch_buffer #(
    parameter int unsigned FETCH_W      = 2,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned SKID_DEPTH   = 2,
    parameter logic [31:0] PC_RESET     = 32'h1c000000,
    parameter logic [31:0] INST_NOP     = 32'h03400000
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                flush,
    if1_fetch_buffer_if.slave                   bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_cnt,
    output logic                                err_unexp_resp
);
    localparam int unsigned SW  = $clog2(FETCH_W);
    localparam int unsigned CW  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned QW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned FW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned SCW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned IW  = FETCH_W * 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        pc_next;
        logic               taken;
        logic [31:0]        badv;
        logic [6:0]         excp;
        logic [1:0]         excp_flag;
        logic [IW-1:0]      inst;
        logic [FETCH_W-1:0] mask;
    } entry_t;

    localparam entry_t RST_ENTRY = '{
        pc:        PC_RESET,
        pc_next:   PC_RESET + 32'd4,
        taken:     1'b0,
        badv:      32'd0,
        excp:      7'd0,
        excp_flag: 2'd0,
        inst:      {FETCH_W{INST_NOP}},
        mask:      '0
    };

    logic [31:0]    pcq [MAX_INFLIGHT];
    logic [QW-1:0]  pcq_rd;
    logic [QW-1:0]  pcq_wr;
    logic [CW-1:0]  drop_cnt;
    entry_t         skid [SKID_DEPTH];
    logic [FW-1:0]  skid_rd;
    logic [FW-1:0]  skid_wr;
    logic [SCW-1:0] skid_cnt;

    logic           resp_ok;
    logic           accept;
    logic           push;
    logic           pop;
    logic [31:0]    head_pc;
    logic [SW-1:0]  shift;
    entry_t         new_entry;
    entry_t         head;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (32'(p) == MAX_INFLIGHT - 1) ? '0 : p + QW'(1);
    endfunction

    function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
        return (32'(p) == SKID_DEPTH - 1) ? '0 : p + FW'(1);
    endfunction

    // Responses with nothing outstanding are protocol errors and never touch the queues.
    assign resp_ok = bus.resp_valid && (inflight_cnt != '0);
    // Occupancy counts every live in-flight request as already holding a skid slot.
    assign bus.req_ready = !flush && (32'(inflight_cnt) < MAX_INFLIGHT) &&
                           ((32'(inflight_cnt) - 32'(drop_cnt) + 32'(skid_cnt)) < SKID_DEPTH);
    assign accept  = bus.req_valid && bus.req_ready;
    assign push    = resp_ok && !flush && (drop_cnt == '0);
    assign pop     = bus.out_valid && bus.out_ready;
    assign head_pc = pcq[pcq_rd];
    assign shift   = head_pc[SW+1:2];

    // Shift the aligned block down so lane 0 is the instruction at the request PC.
    always_comb begin
        new_entry           = RST_ENTRY;
        new_entry.pc        = head_pc;
        new_entry.pc_next   = bus.resp_pc_next;
        new_entry.taken     = bus.resp_taken;
        new_entry.badv      = bus.resp_badv;
        new_entry.excp      = bus.resp_excp;
        new_entry.excp_flag = bus.resp_excp_flag;
        new_entry.mask      = '0;
        for (int j = 0; j < int'(FETCH_W); j++) begin
            for (int k = 0; k < int'(FETCH_W); k++) begin
                if (32'(k) == 32'(j) + 32'(shift)) begin
                    new_entry.inst[j*32 +: 32] = bus.resp_inst[k*32 +: 32];
                    new_entry.mask[j]          = 1'b1;
                end
            end
        end
        if (bus.resp_excp_flag != 2'b00) begin
            new_entry.mask = FETCH_W'(1);
        end
    end

    // Request credits, PC queue and post-flush drop accounting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                pcq[i] <= '0;
            end
            pcq_rd         <= '0;
            pcq_wr         <= '0;
            inflight_cnt   <= '0;
            drop_cnt       <= '0;
            err_unexp_resp <= 1'b0;
        end else begin
            if (accept) begin
                pcq[pcq_wr] <= bus.req_pc;
                pcq_wr      <= q_inc(pcq_wr);
            end
            if (resp_ok) begin
                pcq_rd <= q_inc(pcq_rd);
            end
            case ({accept, resp_ok})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
            if (flush) begin
                drop_cnt <= inflight_cnt - CW'(resp_ok);
            end else if (resp_ok && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (bus.resp_valid && (inflight_cnt == '0)) begin
                err_unexp_resp <= 1'b1;
            end
        end
    end

    // Skid FIFO; a slot is always reserved, so push-while-full only happens alongside a pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid[i] <= RST_ENTRY;
            end
            skid_rd  <= '0;
            skid_wr  <= '0;
            skid_cnt <= '0;
        end else if (flush) begin
            skid_rd  <= skid_wr;
            skid_cnt <= '0;
        end else begin
            if (push) begin
                skid[skid_wr] <= new_entry;
                skid_wr       <= f_inc(skid_wr);
            end
            if (pop) begin
                skid_rd <= f_inc(skid_rd);
            end
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + SCW'(1);
                2'b01:   skid_cnt <= skid_cnt - SCW'(1);
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign head              = skid[skid_rd];
    assign bus.out_valid     = (skid_cnt != '0);
    assign bus.out_pc        = head.pc;
    assign bus.out_pc_next   = head.pc_next;
    assign bus.out_taken     = head.taken;
    assign bus.out_badv      = head.badv;
    assign bus.out_excp      = head.excp;
    assign bus.out_excp_flag = head.excp_flag;
    assign bus.out_inst      = head.inst;
    assign bus.out_mask      = head.mask;
endmodule

// File: tb/tb_if1_fetch_buffer.sv
// Scoreboard bench for if1_fetch_buffer: directed fetches push expected entries,
// a negedge monitor pops and compares on every output handshake.
module tb_if1_fetch_buffer;
    localparam int unsigned FETCH_W = 2;
    localparam logic [31:0] NOP     = 32'h03400000;
    localparam logic [31:0] PCR     = 32'h1c000000;
    localparam logic [31:0] WA      = 32'haaaa0001;
    localparam logic [31:0] WB      = 32'hbbbb0002;
    localparam logic [31:0] WC      = 32'hcccc0003;
    localparam logic [31:0] WD      = 32'hdddd0004;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        taken;
        logic [31:0] badv;
        logic [6:0]  excp;
        logic [1:0]  excp_flag;
        logic [63:0] inst;
        logic [1:0]  mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flush;
    logic [1:0] inflight_cnt;
    logic       err_unexp_resp;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;

    if1_fetch_buffer_if #(.FETCH_W(FETCH_W)) bus();

    if1_fetch_buffer #(
        .FETCH_W(FETCH_W), .MAX_INFLIGHT(2), .SKID_DEPTH(2),
        .PC_RESET(PCR), .INST_NOP(NOP)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus),
        .inflight_cnt(inflight_cnt), .err_unexp_resp(err_unexp_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] pc);
        int n;
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_accept", 64'(bus.req_ready), 64'(1));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_resp(input logic [63:0] inst, input logic [31:0] pc_next, input logic taken,
                           input logic [31:0] badv, input logic [6:0] excp, input logic [1:0] flag);
        bus.resp_valid     = 1'b1;
        bus.resp_inst      = inst;
        bus.resp_pc_next   = pc_next;
        bus.resp_taken     = taken;
        bus.resp_badv      = badv;
        bus.resp_excp      = excp;
        bus.resp_excp_flag = flag;
        tick();
        bus.resp_valid     = 1'b0;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] pc_next, input logic taken,
                                input logic [31:0] badv, input logic [6:0] excp, input logic [1:0] flag,
                                input logic [63:0] inst, input logic [1:0] mask);
        exp_t e;
        e = '{pc: pc, pc_next: pc_next, taken: taken, badv: badv, excp: excp,
              excp_flag: flag, inst: inst, mask: mask};
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"},   64'(bus.out_valid),     64'(0));
        chk({tag, "_out_pc"},      64'(bus.out_pc),        64'(PCR));
        chk({tag, "_out_pc_next"}, 64'(bus.out_pc_next),   64'(32'h1c000004));
        chk({tag, "_out_inst"},    64'(bus.out_inst),      {NOP, NOP});
        chk({tag, "_out_mask"},    64'(bus.out_mask),      64'(0));
        chk({tag, "_out_side"},    64'({bus.out_taken, bus.out_badv, bus.out_excp, bus.out_excp_flag}), 64'(0));
        chk({tag, "_inflight"},    64'(inflight_cnt),      64'(0));
        chk({tag, "_err"},         64'(err_unexp_resp),    64'(0));
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual_pc=%0h expected=none", bus.out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_pc",        64'(bus.out_pc),        64'(mon_e.pc));
                chk("mon_pc_next",   64'(bus.out_pc_next),   64'(mon_e.pc_next));
                chk("mon_taken",     64'(bus.out_taken),     64'(mon_e.taken));
                chk("mon_badv",      64'(bus.out_badv),      64'(mon_e.badv));
                chk("mon_excp",      64'(bus.out_excp),      64'(mon_e.excp));
                chk("mon_excp_flag", 64'(bus.out_excp_flag), 64'(mon_e.excp_flag));
                chk("mon_inst",      64'(bus.out_inst),      mon_e.inst);
                chk("mon_mask",      64'(bus.out_mask),      64'(mon_e.mask));
            end
        end
    end

    initial begin
        rstn = 1'b0; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_pc = '0; bus.resp_valid = 1'b0; bus.resp_inst = '0;
        bus.resp_pc_next = '0; bus.resp_taken = 1'b0; bus.resp_badv = '0; bus.resp_excp = '0;
        bus.resp_excp_flag = '0; bus.out_ready = 1'b1;
        repeat (2) tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));

        // Single aligned fetch; the response must not appear combinationally.
        do_req(32'h1c000000);
        chk("t1_inflight", 64'(inflight_cnt), 64'(1));
        expect_entry(32'h1c000000, 32'h1c000008, 1'b0, 32'h0, 7'h0, 2'b00, {WB, WA}, 2'b11);
        bus.resp_valid = 1'b1; bus.resp_inst = {WB, WA}; bus.resp_pc_next = 32'h1c000008;
        #1;
        chk("t1_no_comb_path", 64'(bus.out_valid), 64'(0));
        tick();
        bus.resp_valid = 1'b0;
        chk("t1_out_valid_next", 64'(bus.out_valid), 64'(1));
        repeat (2) tick();

        // Misaligned fetch: lane 0 takes word 1, lane 1 padded.
        do_req(32'h1c000004);
        expect_entry(32'h1c000004, 32'h1c000008, 1'b0, 32'h0, 7'h0, 2'b00, {NOP, WB}, 2'b01);
        do_resp({WB, WA}, 32'h1c000008, 1'b0, 32'h0, 7'h0, 2'b00);
        repeat (2) tick();

        // Back-pressure: both entries held, credits exhausted, then drained in order.
        bus.out_ready = 1'b0;
        do_req(32'h1c000010);
        do_req(32'h1c000018);
        chk("t3_req_ready_full", 64'(bus.req_ready), 64'(0));
        chk("t3_inflight2", 64'(inflight_cnt), 64'(2));
        expect_entry(32'h1c000010, 32'h1c000018, 1'b0, 32'h0, 7'h0, 2'b00, {WB, WA}, 2'b11);
        expect_entry(32'h1c000018, 32'h1c000040, 1'b1, 32'h0, 7'h0, 2'b00, {WD, WC}, 2'b11);
        do_resp({WB, WA}, 32'h1c000018, 1'b0, 32'h0, 7'h0, 2'b00);
        do_resp({WD, WC}, 32'h1c000040, 1'b1, 32'h0, 7'h0, 2'b00);
        repeat (3) tick();
        chk("t3_held_valid", 64'(bus.out_valid), 64'(1));
        chk("t3_skid_full_ready", 64'(bus.req_ready), 64'(0));
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("t3_drained", 64'(bus.out_valid), 64'(0));
        chk("t3_ready_again", 64'(bus.req_ready), 64'(1));

        // Flush clears a held skid entry and drops the one still in flight.
        bus.out_ready = 1'b0;
        do_req(32'h1c000020);
        do_resp({WD, WC}, 32'h1c000020, 1'b0, 32'h0, 7'h0, 2'b00);
        do_req(32'h1c000028);
        flush = 1'b1;
        #1;
        chk("t4_ready_in_flush", 64'(bus.req_ready), 64'(0));
        tick();
        flush = 1'b0;
        chk("t4_skid_cleared", 64'(bus.out_valid), 64'(0));
        chk("t4_inflight_kept", 64'(inflight_cnt), 64'(1));
        do_resp({WD, WC}, 32'h1c00002c, 1'b0, 32'h0, 7'h0, 2'b00);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_dropped", 64'(bus.out_valid), 64'(0));

        // Flush with two in flight; only the post-flush fetch may surface.
        do_req(32'h1c000030);
        do_req(32'h1c000038);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4b_inflight2", 64'(inflight_cnt), 64'(2));
        do_resp({WB, WA}, 32'h1c000038, 1'b0, 32'h0, 7'h0, 2'b00);
        do_resp({WD, WC}, 32'h1c000040, 1'b0, 32'h0, 7'h0, 2'b00);
        chk("t4b_inflight0", 64'(inflight_cnt), 64'(0));
        chk("t4b_nothing_out", 64'(bus.out_valid), 64'(0));
        do_req(32'h1c000100);
        expect_entry(32'h1c000100, 32'h1c000108, 1'b0, 32'h0, 7'h0, 2'b00, {WD, WC}, 2'b11);
        do_resp({WD, WC}, 32'h1c000108, 1'b0, 32'h0, 7'h0, 2'b00);
        repeat (2) tick();

        // Exception: only lane 0 valid, exception fields forwarded.
        do_req(32'h1c000040);
        expect_entry(32'h1c000040, 32'h1c000080, 1'b1, 32'hdead0040, 7'h08, 2'b01, {WB, WA}, 2'b01);
        do_resp({WB, WA}, 32'h1c000080, 1'b1, 32'hdead0040, 7'h08, 2'b01);
        repeat (2) tick();

        // Unexpected response: sticky error, no entry, no credit change.
        do_resp({WB, WA}, 32'h0, 1'b0, 32'h0, 7'h0, 2'b00);
        chk("t6_err_set", 64'(err_unexp_resp), 64'(1));
        chk("t6_inflight0", 64'(inflight_cnt), 64'(0));
        repeat (3) tick();
        chk("t6_no_entry", 64'(bus.out_valid), 64'(0));
        chk("t6_err_sticky", 64'(err_unexp_resp), 64'(1));

        // Asynchronous reset mid-transfer.
        bus.out_ready = 1'b0;
        do_req(32'h1c000080);
        do_resp({WB, WA}, 32'h1c000088, 1'b0, 32'h0, 7'h0, 2'b00);
        do_req(32'h1c000088);
        chk("t7_pre_valid", 64'(bus.out_valid), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        do_resp({WD, WC}, 32'h0, 1'b0, 32'h0, 7'h0, 2'b00);
        chk("t7_err_after_rst", 64'(err_unexp_resp), 64'(1));
        repeat (2) tick();
        chk("t7_no_entry", 64'(bus.out_valid), 64'(0));

        repeat (4) tick();
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if1_fetch_buffer.md
Name: if1_fetch_buffer

Overview:
- Parametrised IF1 stage that replaces the single stage register between the icache response port and the instruction FIFO.
- Tracks up to MAX_INFLIGHT outstanding icache requests with a credit counter and keeps their PCs in an in-order queue.
- Absorbs responses into a skid FIFO, so a response is never lost when downstream stalls.
- Aligns FETCH_W-wide fetch blocks to the request PC and marks valid lanes. After a flush, it silently discards responses that are still in flight.

Parameters:
- FETCH_W, 2: instructions per icache response. Power of two, ≥2.
- MAX_INFLIGHT, 2: maximum outstanding icache requests.
- SKID_DEPTH, 2: skid FIFO entries. Must be ≥ MAX_INFLIGHT.
- PC_RESET, 32'h1c000000: reset value of out_pc.
- INST_NOP, 32'h03400000: filler for invalid lanes.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush
- req_valid  in  1  IF0 presents a fetch PC
- req_ready  out  1  IF0 fetch accepted (req_valid && req_ready)
- req_pc  in  32  fetch PC
- resp_valid  in  1  icache response valid, one cycle, in order
- resp_inst  in  FETCH_W*32  fetch block; lane i = word i of the aligned block
- resp_pc_next  in  32  predicted next PC
- resp_taken  in  1  prediction taken
- resp_badv  in  32  exception bad VA
- resp_excp  in  7  exception code
- resp_excp_flag  in  2  exception flags
- out_valid  out  1  entry available to the instruction FIFO
- out_ready  in  1  instruction FIFO accepts
- out_pc, out_pc_next, out_badv  out  32  head entry fields
- out_taken  out  1  head entry field
- out_excp  out  7  head entry field
- out_excp_flag  out  2  head entry field
- out_inst  out  FETCH_W*32  aligned instructions; lane 0 = instruction at out_pc
- out_mask  out  FETCH_W  valid lanes
- inflight_cnt  out  clog2(MAX_INFLIGHT+1)  outstanding requests
- err_unexp_resp  out  1  sticky: resp_valid seen with inflight_cnt==0

Behaviour:
- Reset values:
  - inflight_cnt=0, drop_cnt=0, PC queue and skid FIFO empty.
  - out_valid=0, out_pc=PC_RESET, out_pc_next=PC_RESET+4, out_inst=all INST_NOP, out_mask=0.
  - out_taken/out_badv/out_excp/out_excp_flag=0, err_unexp_resp=0.
- req_ready (combinational) = !flush && inflight_cnt<MAX_INFLIGHT && (inflight_cnt - drop_cnt + skid_count) < SKID_DEPTH.
  - Every accepted request therefore has a reserved skid slot.
- Accepting a request pushes req_pc into the PC queue (depth MAX_INFLIGHT).
- inflight_cnt update: +1 on accept, -1 on resp_valid, unchanged when both occur in the same cycle.
- Response handling:
  - Each resp_valid pops the PC-queue head as the response PC (the response carries no PC).
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise, the aligned entry is pushed into the skid FIFO.
- Alignment: s = pc[clog2(FETCH_W)+1:2].
  - out lane j = resp lane s+j for j < FETCH_W-s, with mask bit 1.
  - Remaining lanes = INST_NOP, with mask bit 0.
  - If resp_excp_flag!=0, the mask is forced to 1 on lane 0 only.
- Skid FIFO: first-word-fall-through, registered.
  - Push at edge N gives out_valid at N+1. There is no combinational resp→out path.
  - Pop on out_valid&&out_ready. Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Flush (synchronous, priority over everything except reset):
  - Clears the skid FIFO; out_valid=0 next cycle.
  - Clears the PC queue except the entries still owed responses.
  - drop_cnt <= inflight_cnt - resp_valid.
  - A response arriving in the flush cycle is dropped.
  - No request is accepted in the flush cycle.
- resp_valid with inflight_cnt==0: ignored, err_unexp_resp set. It is cleared only by reset.
- Asynchronous reset mid-operation returns all state to reset values. Responses after reset with no outstanding request set err_unexp_resp.

Test Plan:
- Single fetch, FETCH_W=2: req_pc=0x1c000000, resp lanes {A,B} one cycle later → next cycle out_valid=1, out_inst={A,B}, out_mask=2'b11, out_pc=0x1c000000.
- Misaligned fetch: req_pc=0x1c000004 → out_inst lane0=B, lane1=INST_NOP, out_mask=2'b01.
- Back-pressure: out_ready=0, issue 2 requests, 2 responses.
  - req_ready=0 after the second accept; both entries held.
  - out_ready=1 pops them in order, PCs match request order.
- Flush with 2 in flight: flush, then 2 responses, then a new request 0x1c000100 with its response.
  - The 2 old responses never reach the output.
  - The first out_valid carries out_pc=0x1c000100.
- Exception: resp_excp_flag=2'b01, resp_excp=7'h08 → out_mask=2'b01, out_excp=7'h08, out_badv passed through.
- Protocol error and reset: resp_valid with nothing in flight → err_unexp_resp=1, no output entry. Async rstn low mid-transfer → all outputs at reset values immediately.
